ir_nec_rx: RTL and testbench

- Parametrised NEC-protocol infrared receiver. Successor to the fixed 32-bit, 50 MHz IR decoder.
- Synchronises and filters the raw IR receiver pin, then measures every pulse on a 10 us tick. Timing windows are classified on both edges, so glitches and malformed frames are rejected.
- Decoded words go out through a valid/ready handshake, with error reporting and an overrun indication.
- Sits between the IR receiver pin and the Qsys-side register/bus glue.

---
 rtl/ir_pkg.sv | 50 +++++
 rtl/ir_input_filter.sv | 50 +++++
 rtl/ir_nec_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_ir_nec_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared FSM states, 10 us timing windows and error codes for the NEC receiver.
// The REP_STOP state only exists when IR_REPEAT_EN is defined.
package ir_pkg;

    localparam int TICK_HZ = 100000;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = 10'd1023;

    // Pulse windows in ticks, both ends inclusive
    localparam cnt_t LL_MIN = 10'd800;
    localparam cnt_t LL_MAX = 10'd1000;
    localparam cnt_t LH_MIN = 10'd400;
    localparam cnt_t LH_MAX = 10'd500;
    localparam cnt_t RH_MIN = 10'd200;
    localparam cnt_t RH_MAX = 10'd250;
    localparam cnt_t B_MIN  = 10'd40;
    localparam cnt_t B_MAX  = 10'd72;
    localparam cnt_t B1_MIN = 10'd140;
    localparam cnt_t B1_MAX = 10'd190;
    localparam cnt_t SP_MIN = 10'd40;
    localparam cnt_t SP_MAX = 10'd72;

    localparam logic [2:0] ERR_LEAD_LO = 3'd1;
    localparam logic [2:0] ERR_LEAD_HI = 3'd2;
    localparam logic [2:0] ERR_BIT_LO  = 3'd3;
    localparam logic [2:0] ERR_BIT_HI  = 3'd4;
    localparam logic [2:0] ERR_CHECK   = 3'd5;
    localparam logic [2:0] ERR_STOP    = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LO,
        LEAD_HI,
        BIT_LO,
        BIT_HI,
        STOP
`ifdef IR_REPEAT_EN
        , REP_STOP
`endif
    } state_t;

    function automatic logic in_win(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ir_input_filter.sv
// ir_input_filter: 2-flop synchroniser, FILT_LEN-sample stability filter
// and edge strobes on the filtered level (idle/reset level is 1).
module ir_input_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ir_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       lvl_q;
    logic       lvl_d;
    logic       prev_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Level flips only after FILT_LEN consecutive differing samples
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = 4'd0;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == 4'(FILT_LEN - 1)) begin
                lvl_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            lvl_q  <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= 4'd0;
        end else begin
            sync_q <= {sync_q[0], ir_i};
            lvl_q  <= lvl_d;
            prev_q <= lvl_q;
            cnt_q  <= cnt_d;
        end
    end

    assign rise_o = lvl_q & ~prev_q;
    assign fall_o = ~lvl_q & prev_q;

endmodule

// File: rtl/ir_nec_rx.sv
// ir_nec_rx: parametrised NEC IR receiver with valid/ready output.
// Define IR_REPEAT_EN to decode repeat codes onto oREPEAT.
module ir_nec_rx
    import ir_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int NBITS     = 32,
    parameter int CHECK_INV = 1,
    parameter int FILT_LEN  = 4
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iIRDA,
    input  logic             iREADY,
    output logic             oVALID,
    output logic [NBITS-1:0] oDATA,
    output logic             oERR,
    output logic [2:0]       oERR_CODE,
    output logic             oOVERRUN,
    output logic             oREPEAT,
    output logic             oBUSY
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int IW  = $clog2(NBITS);

    logic             rise, fall, tick, sat, last, chk_ok;
    logic [19:0]      div_q;
    cnt_t             cnt_q;
    state_t           state_q, state_d;
    logic [IW-1:0]    bitcnt_q;
    logic [NBITS-1:0] sr_q, data_q;
    logic             valid_q, err_q, ovr_q;
    logic [2:0]       code_q, code_d;
    logic             err_d, commit_d, shift_d, bit_d, clr_d;
`ifdef IR_REPEAT_EN
    logic             rep_d, rep_q, rep_ok_q;
`endif

    ir_input_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk_i (iCLK),
        .rst_ni(iRST_n),
        .ir_i  (iIRDA),
        .rise_o(rise),
        .fall_o(fall)
    );

    assign tick = (div_q == 20'(DIV - 1));
    assign sat  = (cnt_q == CNT_MAX);
    assign last = (bitcnt_q == IW'(NBITS - 1));

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 20'd1;
            if (rise || fall) cnt_q <= '0;
            else if (tick && !sat) cnt_q <= cnt_q + 10'd1;
        end
    end

    generate
        if (CHECK_INV == 1 && NBITS == 32) begin : g_inv
            assign chk_ok = (sr_q[31:24] == ~sr_q[23:16]);
        end else begin : g_noinv
            assign chk_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge iCLK) begin
        if (!iRST_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Every rejection and every timeout falls straight back to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fall) state_d = LEAD_LO;
            LEAD_LO: begin
                if (rise) state_d = in_win(cnt_q, LL_MIN, LL_MAX) ? LEAD_HI : IDLE;
                else if (sat) state_d = IDLE;
            end
            LEAD_HI: begin
                if (fall) begin
                    if (in_win(cnt_q, LH_MIN, LH_MAX)) state_d = BIT_LO;
`ifdef IR_REPEAT_EN
                    else if (rep_ok_q && in_win(cnt_q, RH_MIN, RH_MAX)) state_d = REP_STOP;
`endif
                    else state_d = IDLE;
                end else if (sat) state_d = IDLE;
            end
            BIT_LO: begin
                if (rise) state_d = in_win(cnt_q, B_MIN, B_MAX) ? BIT_HI : IDLE;
                else if (sat) state_d = IDLE;
            end
            BIT_HI: begin
                if (fall) begin
                    if (in_win(cnt_q, B_MIN, B_MAX) || in_win(cnt_q, B1_MIN, B1_MAX))
                        state_d = last ? STOP : BIT_LO;
                    else
                        state_d = IDLE;
                end else if (sat) state_d = IDLE;
            end
            STOP: if (rise || sat) state_d = IDLE;
`ifdef IR_REPEAT_EN
            REP_STOP: if (rise || sat) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d    = 1'b0;
        code_d   = 3'd0;
        commit_d = 1'b0;
        shift_d  = 1'b0;
        bit_d    = 1'b0;
        clr_d    = 1'b0;
`ifdef IR_REPEAT_EN
        rep_d    = 1'b0;
`endif
        unique case (state_q)
            LEAD_LO: begin
                if (rise && !in_win(cnt_q, LL_MIN, LL_MAX)) begin
                    err_d = 1'b1; code_d = ERR_LEAD_LO;
                end else if (!rise && sat) begin
                    err_d = 1'b1; code_d = ERR_TIMEOUT;
                end
            end
            LEAD_HI: begin
                if (fall) begin
                    if (in_win(cnt_q, LH_MIN, LH_MAX)) clr_d = 1'b1;
`ifdef IR_REPEAT_EN
                    else if (rep_ok_q && in_win(cnt_q, RH_MIN, RH_MAX)) clr_d = 1'b0;
`endif
                    else begin
                        err_d = 1'b1; code_d = ERR_LEAD_HI;
                    end
                end
            end
            BIT_LO: begin
                if (rise && !in_win(cnt_q, B_MIN, B_MAX)) begin
                    err_d = 1'b1; code_d = ERR_BIT_LO;
                end else if (!rise && sat) begin
                    err_d = 1'b1; code_d = ERR_TIMEOUT;
                end
            end
            BIT_HI: begin
                if (fall) begin
                    if (in_win(cnt_q, B_MIN, B_MAX)) begin
                        shift_d = 1'b1;
                    end else if (in_win(cnt_q, B1_MIN, B1_MAX)) begin
                        shift_d = 1'b1; bit_d = 1'b1;
                    end else begin
                        err_d = 1'b1; code_d = ERR_BIT_HI;
                    end
                end
            end
            STOP: begin
                if (rise) begin
                    if (!in_win(cnt_q, SP_MIN, SP_MAX)) begin
                        err_d = 1'b1; code_d = ERR_STOP;
                    end else if (!chk_ok) begin
                        err_d = 1'b1; code_d = ERR_CHECK;
                    end else begin
                        commit_d = 1'b1;
                    end
                end else if (sat) begin
                    err_d = 1'b1; code_d = ERR_TIMEOUT;
                end
            end
`ifdef IR_REPEAT_EN
            REP_STOP: begin
                if (rise) begin
                    if (in_win(cnt_q, SP_MIN, SP_MAX)) rep_d = 1'b1;
                    else begin
                        err_d = 1'b1; code_d = ERR_STOP;
                    end
                end else if (sat) begin
                    err_d = 1'b1; code_d = ERR_TIMEOUT;
                end
            end
`endif
            default: clr_d = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            sr_q     <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 3'd0;
            ovr_q    <= 1'b0;
`ifdef IR_REPEAT_EN
            rep_q    <= 1'b0;
            rep_ok_q <= 1'b0;
`endif
        end else begin
            err_q <= err_d;
            ovr_q <= 1'b0;
            if (err_d) code_q <= code_d;
            if (clr_d) begin
                sr_q     <= '0;
                bitcnt_q <= '0;
            end else if (shift_d) begin
                sr_q[bitcnt_q] <= bit_d;
                bitcnt_q       <= bitcnt_q + IW'(1);
            end
            if (commit_d) begin
                data_q  <= sr_q;
                valid_q <= 1'b1;
                ovr_q   <= valid_q && !iREADY;
            end else if (valid_q && iREADY) begin
                valid_q <= 1'b0;
            end
`ifdef IR_REPEAT_EN
            rep_q <= rep_d;
            if (err_d) rep_ok_q <= 1'b0;
            else if (commit_d) rep_ok_q <= 1'b1;
`endif
        end
    end

    assign oVALID    = valid_q;
    assign oDATA     = data_q;
    assign oERR      = err_q;
    assign oERR_CODE = code_q;
    assign oOVERRUN  = ovr_q;
    assign oBUSY     = (state_q != IDLE);
`ifdef IR_REPEAT_EN
    assign oREPEAT   = rep_q;
`else
    assign oREPEAT   = 1'b0;
`endif

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb_ir_nec_rx: randomized NEC frames against a transaction-level model;
// a negedge monitor pops expected events from a scoreboard queue.
module tb_ir_nec_rx;

    localparam int CLK_HZ   = 100000;
    localparam int NBITS    = 32;
    localparam int FILT_LEN = 4;

    localparam int K_DATA = 0;
    localparam int K_ERR  = 1;
    localparam int K_OVR  = 2;
    localparam int K_REP  = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        irda  = 1'b1;
    logic        ready = 1'b0;
    logic        o_valid, o_err, o_ovr, o_rep, o_busy;
    logic [31:0] o_data;
    logic [2:0]  o_code;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          pend = 0;
    logic [31:0] pend_d = '0;
    bit          rdy_mode = 0;
    bit          rep_ok = 0;
    bit          busy_seen = 0;
    logic [31:0] last_d;

    always #5 clk = ~clk;

    ir_nec_rx #(
        .CLK_HZ(CLK_HZ), .NBITS(NBITS), .CHECK_INV(1), .FILT_LEN(FILT_LEN)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iIRDA(irda), .iREADY(ready),
        .oVALID(o_valid), .oDATA(o_data), .oERR(o_err), .oERR_CODE(o_code),
        .oOVERRUN(o_ovr), .oREPEAT(o_rep), .oBUSY(o_busy)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endfunction

    function automatic void pop(input int kind, input logic [31:0] val, input string nm);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected actual=%h required=none", nm, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                errors++;
                $display("FAIL %s actual=%0d/%h required=%0d/%h", nm, kind, val, e.kind, e.val);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_busy) busy_seen = 1;
            if (o_err) pop(K_ERR, {29'd0, o_code}, "err");
            if (o_rep) pop(K_REP, 32'd0, "repeat");
            if (o_ovr) pop(K_OVR, 32'd0, "overrun");
            if (o_valid && ready) pop(K_DATA, o_data, "data");
        end
    end

    // Reference model: frame-level outcomes, not cycle behaviour
    function automatic void exp_err(input int c);
        exp_q.push_back('{kind: K_ERR, val: 32'(c)});
        rep_ok = 0;
    endfunction

    function automatic void exp_commit(input logic [31:0] d);
        rep_ok = 1;
        if (rdy_mode) begin
            exp_q.push_back('{kind: K_DATA, val: d});
        end else begin
            if (pend) exp_q.push_back('{kind: K_OVR, val: 32'd0});
            pend   = 1;
            pend_d = d;
        end
    endfunction

    function automatic void exp_frame(input logic [31:0] d);
        if (d[31:24] == ~d[23:16]) exp_commit(d);
        else exp_err(5);
    endfunction

    function automatic void exp_rep();
`ifdef IR_REPEAT_EN
        if (rep_ok) exp_q.push_back('{kind: K_REP, val: 32'd0});
        else exp_err(2);
`else
        exp_err(2);
`endif
    endfunction

    function automatic void give_ready();
        ready    = 1'b1;
        rdy_mode = 1;
        if (pend) exp_q.push_back('{kind: K_DATA, val: pend_d});
        pend = 0;
    endfunction

    function automatic int rr(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic logic [31:0] mk_good();
        logic [7:0] b;
        b = 8'($urandom);
        return {~b, b, 16'($urandom)};
    endfunction

    task automatic hold(input logic lvl, input int n);
        irda = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input int abort_bit,
                        input int bad_bit, input int bad_kind);
        hold(1'b0, rr(810, 990));
        hold(1'b1, rr(410, 490));
        for (int i = 0; i < 32; i++) begin
            if (i == bad_bit && bad_kind == 3) begin
                hold(1'b0, rr(80, 120));
                hold(1'b1, 200);
                return;
            end
            hold(1'b0, rr(45, 67));
            if (i == abort_bit) return;
            if (i == bad_bit && bad_kind == 4) begin
                hold(1'b1, rr(80, 130));
                hold(1'b0, 56);
                hold(1'b1, 200);
                return;
            end
            hold(1'b1, d[i] ? rr(145, 185) : rr(45, 67));
        end
        hold(1'b0, rr(45, 67));
        hold(1'b1, 100);
    endtask

    task automatic send_rep();
        hold(1'b0, rr(810, 990));
        hold(1'b1, rr(205, 245));
        hold(1'b0, rr(45, 67));
        hold(1'b1, 100);
    endtask

    initial begin
        #(98000 * 10);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          sel;
        int          kind;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_code", 32'(o_code), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_pulses", {29'd0, o_err, o_ovr, o_rep}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        exp_frame(32'hE51A00FF);
        send(32'hE51A00FF, -1, -1, 0);
        hold(1'b1, 20);
        chk("t1_valid", 32'(o_valid), 32'd1);
        chk("t1_data", o_data, 32'hE51A00FF);
        give_ready();
        hold(1'b1, 1);
        ready    = 1'b0;
        rdy_mode = 0;
        chk("t1_cleared", 32'(o_valid), 32'd0);

        exp_frame(32'hE51B00FF);
        send(32'hE51B00FF, -1, -1, 0);
        hold(1'b1, 50);
        chk("t2_valid", 32'(o_valid), 32'd0);

        exp_frame(32'h10EF00FF);
        send(32'h10EF00FF, -1, -1, 0);
        hold(1'b1, 50);
        exp_frame(32'h20DF00FF);
        send(32'h20DF00FF, -1, -1, 0);
        hold(1'b1, 50);
        chk("t3_valid", 32'(o_valid), 32'd1);
        chk("t3_data", o_data, 32'h20DF00FF);
        give_ready();
        hold(1'b1, 5);

        exp_err(1);
        hold(1'b0, 700);
        hold(1'b1, 1200);
        d = mk_good();
        exp_frame(d);
        send(d, -1, -1, 0);
        hold(1'b1, 50);

        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            hold(1'b0, rr(1, FILT_LEN - 1));
            hold(1'b1, rr(FILT_LEN, 30));
        end
        hold(1'b1, 20);
        chk("glitch_busy", 32'(busy_seen), 32'd0);

        send(mk_good(), 17, -1, 0);
        chk("mid_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        hold(1'b1, 3);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_data", o_data, 32'd0);
        chk("mid_rst_code", 32'(o_code), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        pend   = 0;
        rep_ok = 0;
        rst_n  = 1'b1;
        hold(1'b1, 20);

        exp_rep();
        send_rep();
        hold(1'b1, 50);
        last_d = mk_good();
        exp_frame(last_d);
        send(last_d, -1, -1, 0);
        hold(1'b1, 50);
        exp_rep();
        send_rep();
        hold(1'b1, 50);
        chk("rep_data_held", o_data, last_d);

        for (int n = 0; n < 2; n++) begin
            sel = rr(0, 3);
            d   = mk_good();
            case (sel)
                0: begin
                    exp_frame(d);
                    send(d, -1, -1, 0);
                end
                1: begin
                    d = d ^ 32'h0100_0000;
                    exp_frame(d);
                    send(d, -1, -1, 0);
                end
                2: begin
                    kind = rr(3, 4);
                    exp_err(kind);
                    send(d, -1, rr(0, 31), kind);
                end
                default: begin
                    exp_rep();
                    send_rep();
                end
            endcase
            hold(1'b1, 100);
        end

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
